cache_way_array: RTL and testbench
==================================

// Module: cache_way_array
// PURPOSE
//  N-way set-associative tag/valid/data array for the PULPino instruction/data cache.
//  Compares tags in all ways in parallel and returns hit, hit way, line and a victim way.
//  Sits between the cache controller FSM and per-way sp_ram_wrap instances.
//  Also handles fills, flush and replacement state (successor to the single-way-access wrapper).
// PARAMETERS
//  WAY_COUNT       2    ways per set, power of two, 1..8
//  SET_COUNT       64   sets, power of two, >=2
//  WAY_WORD_COUNT  4    32-bit words per line, power of two
//  Derived: SET_W=$clog2(SET_COUNT); WAY_W=max(1,$clog2(WAY_COUNT));
//           TAG_W=32-2-$clog2(WAY_WORD_COUNT)-SET_W; LINE_W=32*WAY_WORD_COUNT
// PORTS
//  clk                 in   1          clock
//  rstn_i              in   1          reset, asynchronous, active-low
//  flush_i             in   1          pulse: invalidate all lines
//  busy_o              out  1          init/flush sweep in progress
//  req_valid_i         in   1          lookup request
//  req_ready_o         out  1          lookup accepted when valid&ready
//  req_set_i           in   SET_W      lookup set index
//  req_tag_i           in   TAG_W      lookup tag
//  resp_valid_o        out  1          lookup result valid (one cycle)
//  resp_hit_o          out  1          some valid way matched tag
//  resp_way_o          out  WAY_W      hit way (0 on miss)
//  resp_line_o         out  LINE_W     data of hit way (0 on miss)
//  resp_victim_way_o   out  WAY_W      way to refill on miss
//  fill_valid_i        in   1          write line (always accepted)
//  fill_set_i          in   SET_W      fill set
//  fill_way_i          in   WAY_W      fill way
//  fill_tag_i          in   TAG_W      fill tag
//  fill_line_i         in   LINE_W     fill data
//  fill_be_i           in   LINE_W/8   fill byte enables
// BEHAVIOUR
//  - States: INIT, IDLE. Reset -> INIT. INIT clears valid of every way, one set/cycle,
//    set counter 0..SET_COUNT-1, then IDLE. busy_o=1 in INIT.
//  - Reset values: busy_o=1, req_ready_o=0, resp_valid_o=0, resp_hit_o=0, resp_way_o=0,
//    resp_line_o=0, resp_victim_way_o=0, replacement state all 0.
//  - req_ready_o = (state==IDLE) & ~fill_valid_i & ~flush_i.
//  - Lookup: accepted cycle T -> resp_* valid at T+1 for exactly one cycle; back-to-back allowed.
//  - Hit = valid[w] & tag[w]==req_tag; multiple matches impossible by construction; lowest index wins.
//  - Victim: lowest-index invalid way if any, else replacement-policy way.
//  - Replacement state updated at T+1 on hit (hit way) and on every fill (fill way).
//  - Fill: sets valid, writes tag, writes data under fill_be_i, same cycle; fill in INIT ignored.
//  - Lookup at T+1 to set filled at T sees filled data.
//  - flush_i in IDLE: counter reset to 0, enter INIT; response in flight still delivered at T+1.
//    flush_i in INIT restarts sweep from set 0.
//  - rstn_i low mid-operation: all state/outputs to reset values immediately; RAM contents
//    irrelevant because INIT clears valids.
//  - WAY_COUNT=1: victim always 0, no replacement state.
// CONFIGURATION
//  CACHE_PLRU_EN defined: per-set tree pseudo-LRU, WAY_COUNT-1 bits/set; hit/fill flips
//    tree nodes away from accessed way; victim follows node bits from root (0=left).
//  CACHE_PLRU_EN undefined: one global round-robin WAY_W counter, incremented (wrapping)
//    on every fill; victim = counter value.
// STRUCTURE
//  cache_pkg: SET_W/TAG_W/WAY_W functions, typedef struct {valid,tag} cache_meta_t,
//    typedef enum {INIT, IDLE} cache_arr_state_e.
//  Sub-module cache_repl (victim select + state update, both policies behind macro).
//  Per-way sp_ram_wrap for data; valid bits in flops (flash clear not needed, sweep kept for
//  uniformity with tag RAM); tag per way in sp_ram_wrap.
// TESTING
//  1 Reset, then hold -> busy_o=1 for exactly 64 cycles, req_ready_o=1 on cycle 65.
//  2 Fill set 5 way 1 tag 0x1234 line 0xA..; lookup set 5 tag 0x1234 -> T+1 hit=1, way=1, line matches.
//  3 Lookup set 5 tag 0x4321 after test 2 -> hit=0, line=0, victim_way=0 (way 0 invalid).
//  4 Fill both ways set 9; PLRU: hit way 0 then miss -> victim 1; RR: victims alternate 0,1,0.
//  5 fill_valid_i with req_valid_i same cycle -> req_ready_o=0, request accepted next cycle.
//  6 flush_i after fills -> busy_o 64 cycles, then lookup of filled tags -> hit=0.

Source files
------------

// File: rtl/cache_pkg.sv
// Shared width helpers, metadata record and array state type for the cache way array.
package cache_pkg;

    localparam int CACHE_TAG_MAX_W = 30;

    function automatic int set_w(input int set_count);
        return (set_count > 1) ? $clog2(set_count) : 1;
    endfunction

    function automatic int way_w(input int way_count);
        return (way_count > 1) ? $clog2(way_count) : 1;
    endfunction

    function automatic int tag_w(input int set_count, input int word_count);
        return 32 - 2 - $clog2(word_count) - $clog2(set_count);
    endfunction

    typedef struct packed {
        logic                       valid;
        logic [CACHE_TAG_MAX_W-1:0] tag;
    } cache_meta_t;

    typedef enum logic {
        INIT = 1'b0,
        IDLE = 1'b1
    } cache_arr_state_e;

endpackage

// File: rtl/cache_repl.sv
// Victim selection and replacement state for the cache way array.
// CACHE_PLRU_EN defined: per-set tree pseudo-LRU; undefined: one global round-robin counter.
module cache_repl
    import cache_pkg::*;
#(
    parameter  int WAY_COUNT = 2,
    parameter  int SET_COUNT = 64,
    localparam int SET_W     = set_w(SET_COUNT),
    localparam int WAY_W     = way_w(WAY_COUNT)
) (
    input  logic                 clk,
    input  logic                 rstn_i,
    input  logic [SET_W-1:0]     lookup_set_i,
    input  logic [WAY_COUNT-1:0] lookup_valid_i,
    input  logic                 hit_valid_i,
    input  logic [SET_W-1:0]     hit_set_i,
    input  logic [WAY_W-1:0]     hit_way_i,
    input  logic                 fill_valid_i,
    input  logic [SET_W-1:0]     fill_set_i,
    input  logic [WAY_W-1:0]     fill_way_i,
    output logic [WAY_W-1:0]     victim_way_o
);

    logic [WAY_W-1:0] policy_way;
    logic [WAY_W-1:0] free_way;
    logic             free_found;

    // Downward scan so the lowest-index invalid way is the one left standing.
    always_comb begin
        free_found = 1'b0;
        free_way   = '0;
        for (int w = WAY_COUNT - 1; w >= 0; w--) begin
            if (!lookup_valid_i[w]) begin
                free_found = 1'b1;
                free_way   = WAY_W'(w);
            end
        end
    end

    assign victim_way_o = free_found ? free_way : policy_way;

    if (WAY_COUNT == 1) begin : g_single
        logic unused_repl;
        assign unused_repl = ^{clk, rstn_i, lookup_set_i, hit_valid_i, hit_set_i, hit_way_i,
                               fill_valid_i, fill_set_i, fill_way_i};
        assign policy_way  = '0;
    end else begin : g_multi
`ifdef CACHE_PLRU_EN
        localparam int LVL   = $clog2(WAY_COUNT);
        localparam int NODES = WAY_COUNT - 1;

        logic [NODES-1:0] tree_q [SET_COUNT];
        logic [NODES-1:0] hit_tree;
        logic [NODES-1:0] fill_tree;

        function automatic logic [WAY_W-1:0] tree_victim(input logic [NODES-1:0] tree);
            int               node;
            logic             dir;
            logic [WAY_W-1:0] way;
            node = 0;
            way  = '0;
            for (int l = 0; l < LVL; l++) begin
                dir  = tree[node];
                way  = WAY_W'({way, dir});
                node = 2 * node + 1 + (dir ? 1 : 0);
            end
            return way;
        endfunction

        // Point every node on the accessed way's path at the opposite subtree.
        function automatic logic [NODES-1:0] tree_touch(input logic [NODES-1:0] tree,
                                                        input logic [WAY_W-1:0] way);
            logic [NODES-1:0] t;
            int               node;
            logic             dir;
            t    = tree;
            node = 0;
            for (int l = 0; l < LVL; l++) begin
                dir     = way[LVL-1-l];
                t[node] = ~dir;
                node    = 2 * node + 1 + (dir ? 1 : 0);
            end
            return t;
        endfunction

        always_comb begin
            hit_tree  = tree_touch(tree_q[hit_set_i], hit_way_i);
            fill_tree = tree_q[fill_set_i];
            if (hit_valid_i && (hit_set_i == fill_set_i)) begin
                fill_tree = tree_touch(fill_tree, hit_way_i);
            end
            fill_tree = tree_touch(fill_tree, fill_way_i);
        end

        always_ff @(posedge clk or negedge rstn_i) begin
            if (!rstn_i) begin
                for (int s = 0; s < SET_COUNT; s++) begin
                    tree_q[s] <= '0;
                end
            end else begin
                if (hit_valid_i) begin
                    tree_q[hit_set_i] <= hit_tree;
                end
                if (fill_valid_i) begin
                    tree_q[fill_set_i] <= fill_tree;
                end
            end
        end

        assign policy_way = tree_victim(tree_q[lookup_set_i]);
`else
        logic [WAY_W-1:0] rr_q;
        logic             unused_repl;

        assign unused_repl = ^{lookup_set_i, hit_valid_i, hit_set_i, hit_way_i,
                               fill_set_i, fill_way_i};

        always_ff @(posedge clk or negedge rstn_i) begin
            if (!rstn_i) begin
                rr_q <= '0;
            end else if (fill_valid_i) begin
                rr_q <= rr_q + 1'b1;
            end
        end

        assign policy_way = rr_q;
`endif
    end

endmodule

// File: rtl/cache_way_array.sv
// N-way set-associative tag/valid/data array: parallel tag compare, fills, flush sweep.
// CACHE_PLRU_EN selects tree pseudo-LRU replacement; otherwise global round-robin.
//
// state | meaning
// INIT  | clearing valid bits one set per cycle; busy_o high, no lookups or fills
// IDLE  | accepting lookups and fills
module cache_way_array
    import cache_pkg::*;
#(
    parameter  int WAY_COUNT      = 2,
    parameter  int SET_COUNT      = 64,
    parameter  int WAY_WORD_COUNT = 4,
    localparam int SET_W          = set_w(SET_COUNT),
    localparam int WAY_W          = way_w(WAY_COUNT),
    localparam int TAG_W          = tag_w(SET_COUNT, WAY_WORD_COUNT),
    localparam int LINE_W         = 32 * WAY_WORD_COUNT,
    localparam int BE_W           = LINE_W / 8
) (
    input  logic              clk,
    input  logic              rstn_i,
    input  logic              flush_i,
    output logic              busy_o,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic [SET_W-1:0]  req_set_i,
    input  logic [TAG_W-1:0]  req_tag_i,
    output logic              resp_valid_o,
    output logic              resp_hit_o,
    output logic [WAY_W-1:0]  resp_way_o,
    output logic [LINE_W-1:0] resp_line_o,
    output logic [WAY_W-1:0]  resp_victim_way_o,
    input  logic              fill_valid_i,
    input  logic [SET_W-1:0]  fill_set_i,
    input  logic [WAY_W-1:0]  fill_way_i,
    input  logic [TAG_W-1:0]  fill_tag_i,
    input  logic [LINE_W-1:0] fill_line_i,
    input  logic [BE_W-1:0]   fill_be_i
);

    localparam logic [SET_W-1:0] LAST_SET = SET_W'(SET_COUNT - 1);

    cache_arr_state_e     state_q, state_d;
    logic [SET_W-1:0]     sweep_set_q, sweep_set_d;
    logic [SET_COUNT-1:0] valid_q  [WAY_COUNT];
    logic [TAG_W-1:0]     tag_mem  [WAY_COUNT][SET_COUNT];
    logic [LINE_W-1:0]    data_mem [WAY_COUNT][SET_COUNT];

    cache_meta_t          meta [WAY_COUNT];
    logic [WAY_COUNT-1:0] set_valid;
    logic                 lookup_hit;
    logic [WAY_W-1:0]     lookup_way;
    logic [LINE_W-1:0]    lookup_line;
    logic [WAY_W-1:0]     victim_way;
    logic [SET_W-1:0]     resp_set_q;
    logic                 accept;
    logic                 fill_en;

    assign busy_o      = (state_q == INIT);
    assign req_ready_o = (state_q == IDLE) & ~fill_valid_i & ~flush_i;
    assign accept      = req_valid_i & req_ready_o;
    assign fill_en     = fill_valid_i & (state_q == IDLE);

    always_comb begin
        state_d     = state_q;
        sweep_set_d = sweep_set_q;
        case (state_q)
            INIT: begin
                if (flush_i) begin
                    sweep_set_d = '0;
                end else if (sweep_set_q == LAST_SET) begin
                    state_d     = IDLE;
                    sweep_set_d = '0;
                end else begin
                    sweep_set_d = sweep_set_q + 1'b1;
                end
            end
            IDLE: begin
                if (flush_i) begin
                    state_d     = INIT;
                    sweep_set_d = '0;
                end
            end
            default: begin
                state_d     = INIT;
                sweep_set_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q     <= INIT;
            sweep_set_q <= '0;
        end else begin
            state_q     <= state_d;
            sweep_set_q <= sweep_set_d;
        end
    end

    always_ff @(posedge clk or negedge rstn_i) begin
        if (!rstn_i) begin
            for (int w = 0; w < WAY_COUNT; w++) begin
                valid_q[w] <= '0;
            end
        end else begin
            for (int w = 0; w < WAY_COUNT; w++) begin
                if (state_q == INIT) begin
                    valid_q[w][sweep_set_q] <= 1'b0;
                end else if (fill_en && (fill_way_i == WAY_W'(w))) begin
                    valid_q[w][fill_set_i] <= 1'b1;
                end
            end
        end
    end

    // Array contents are not reset; the INIT sweep makes stale entries unreachable.
    always_ff @(posedge clk) begin
        for (int w = 0; w < WAY_COUNT; w++) begin
            if (fill_en && (fill_way_i == WAY_W'(w))) begin
                tag_mem[w][fill_set_i] <= fill_tag_i;
                for (int b = 0; b < BE_W; b++) begin
                    if (fill_be_i[b]) begin
                        data_mem[w][fill_set_i][b*8 +: 8] <= fill_line_i[b*8 +: 8];
                    end
                end
            end
        end
    end

    // Scanning downward leaves the lowest matching way as the result.
    always_comb begin
        meta        = '{default: '0};
        set_valid   = '0;
        lookup_hit  = 1'b0;
        lookup_way  = '0;
        lookup_line = '0;
        for (int w = WAY_COUNT - 1; w >= 0; w--) begin
            meta[w].valid = valid_q[w][req_set_i];
            meta[w].tag   = CACHE_TAG_MAX_W'(tag_mem[w][req_set_i]);
            set_valid[w]  = meta[w].valid;
            if (meta[w].valid && (meta[w].tag == CACHE_TAG_MAX_W'(req_tag_i))) begin
                lookup_hit  = 1'b1;
                lookup_way  = WAY_W'(w);
                lookup_line = data_mem[w][req_set_i];
            end
        end
    end

    cache_repl #(
        .WAY_COUNT (WAY_COUNT),
        .SET_COUNT (SET_COUNT)
    ) u_repl (
        .clk            (clk),
        .rstn_i         (rstn_i),
        .lookup_set_i   (req_set_i),
        .lookup_valid_i (set_valid),
        .hit_valid_i    (resp_valid_o & resp_hit_o),
        .hit_set_i      (resp_set_q),
        .hit_way_i      (resp_way_o),
        .fill_valid_i   (fill_en),
        .fill_set_i     (fill_set_i),
        .fill_way_i     (fill_way_i),
        .victim_way_o   (victim_way)
    );

    always_ff @(posedge clk or negedge rstn_i) begin
        if (!rstn_i) begin
            resp_valid_o      <= 1'b0;
            resp_hit_o        <= 1'b0;
            resp_way_o        <= '0;
            resp_line_o       <= '0;
            resp_victim_way_o <= '0;
            resp_set_q        <= '0;
        end else begin
            resp_valid_o <= accept;
            if (accept) begin
                resp_hit_o        <= lookup_hit;
                resp_way_o        <= lookup_way;
                resp_line_o       <= lookup_line;
                resp_victim_way_o <= victim_way;
                resp_set_q        <= req_set_i;
            end
        end
    end

endmodule

// File: tb/tb_cache_way_array.sv
// Self-checking bench for cache_way_array: directed scenarios plus randomized traffic
// compared against a set/way array model in the bench.
module tb_cache_way_array;

    localparam int WAYS   = 2;
    localparam int SETS   = 64;
    localparam int TAG_W  = 22;
    localparam int LINE_W = 128;
    localparam int BE_W   = 16;

    logic              clk;
    logic              rstn_i;
    logic              flush_i;
    logic              busy_o;
    logic              req_valid_i;
    logic              req_ready_o;
    logic [5:0]        req_set_i;
    logic [TAG_W-1:0]  req_tag_i;
    logic              resp_valid_o;
    logic              resp_hit_o;
    logic [0:0]        resp_way_o;
    logic [LINE_W-1:0] resp_line_o;
    logic [0:0]        resp_victim_way_o;
    logic              fill_valid_i;
    logic [5:0]        fill_set_i;
    logic [0:0]        fill_way_i;
    logic [TAG_W-1:0]  fill_tag_i;
    logic [LINE_W-1:0] fill_line_i;
    logic [BE_W-1:0]   fill_be_i;

    cache_way_array dut (
        .clk               (clk),
        .rstn_i            (rstn_i),
        .flush_i           (flush_i),
        .busy_o            (busy_o),
        .req_valid_i       (req_valid_i),
        .req_ready_o       (req_ready_o),
        .req_set_i         (req_set_i),
        .req_tag_i         (req_tag_i),
        .resp_valid_o      (resp_valid_o),
        .resp_hit_o        (resp_hit_o),
        .resp_way_o        (resp_way_o),
        .resp_line_o       (resp_line_o),
        .resp_victim_way_o (resp_victim_way_o),
        .fill_valid_i      (fill_valid_i),
        .fill_set_i        (fill_set_i),
        .fill_way_i        (fill_way_i),
        .fill_tag_i        (fill_tag_i),
        .fill_line_i       (fill_line_i),
        .fill_be_i         (fill_be_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: what the array should hold and which way it should pick.
    bit                m_valid   [WAYS][SETS];
    bit                m_written [WAYS][SETS];
    logic [TAG_W-1:0]  m_tag     [WAYS][SETS];
    logic [LINE_W-1:0] m_data    [WAYS][SETS];
    bit                m_tree    [SETS][WAYS-1];
    int                m_rr;
    int                busy_left;
    bit                pend_v;
    int                pend_set;
    int                pend_way;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int w = 0; w < WAYS; w++)
            for (int s = 0; s < SETS; s++) m_valid[w][s] = 0;
        for (int s = 0; s < SETS; s++)
            for (int n = 0; n < WAYS - 1; n++) m_tree[s][n] = 0;
        m_rr      = 0;
        busy_left = SETS;
        pend_v    = 0;
    endtask

    function automatic int policy_victim(input int s);
`ifdef CACHE_PLRU_EN
        int node = 0;
        int way  = 0;
        for (int l = 0; l < $clog2(WAYS); l++) begin
            way  = way * 2 + int'(m_tree[s][node]);
            node = 2 * node + 1 + int'(m_tree[s][node]);
        end
        return way;
`else
        return m_rr;
`endif
    endfunction

    task automatic touch(input int s, input int w, input bit is_fill);
`ifdef CACHE_PLRU_EN
        int node = 0;
        int dir;
        for (int l = 0; l < $clog2(WAYS); l++) begin
            dir            = (w >> ($clog2(WAYS) - 1 - l)) & 1;
            m_tree[s][node] = (dir == 0);
            node           = 2 * node + 1 + dir;
        end
`else
        if (is_fill) m_rr = (m_rr + 1) % WAYS;
`endif
    endtask

    // One clock cycle: drive at edge+1, check ready, advance, check the response.
    task automatic drive_cycle(input bit fv, input int fset, input int fway,
                               input logic [TAG_W-1:0] ftag, input logic [LINE_W-1:0] fline,
                               input logic [BE_W-1:0] fbe, input bit rv, input int rset,
                               input logic [TAG_W-1:0] rtag, input bit fl);
        bit                idle, exp_ready, acc, e_hit;
        int                e_way, e_vict;
        logic [LINE_W-1:0] e_line;
        fill_valid_i = fv;
        fill_set_i   = 6'(fset);
        fill_way_i   = 1'(fway);
        fill_tag_i   = ftag;
        fill_line_i  = fline;
        fill_be_i    = fbe;
        req_valid_i  = rv;
        req_set_i    = 6'(rset);
        req_tag_i    = rtag;
        flush_i      = fl;
        #1;
        idle      = (busy_left == 0);
        exp_ready = idle && !fv && !fl;
        check_eq("req_ready", req_ready_o, exp_ready);
        acc    = rv && exp_ready;
        e_hit  = 0;
        e_way  = 0;
        e_line = '0;
        e_vict = -1;
        if (acc) begin
            for (int w = 0; w < WAYS; w++)
                if (!e_hit && m_valid[w][rset] && m_tag[w][rset] == rtag) begin
                    e_hit  = 1;
                    e_way  = w;
                    e_line = m_data[w][rset];
                end
            for (int w = 0; w < WAYS; w++)
                if (e_vict < 0 && !m_valid[w][rset]) e_vict = w;
            if (e_vict < 0) e_vict = policy_victim(rset);
        end
        if (pend_v) touch(pend_set, pend_way, 0);
        if (fv && idle) begin
            m_valid[fway][fset]   = 1;
            m_written[fway][fset] = 1;
            m_tag[fway][fset]     = ftag;
            for (int b = 0; b < BE_W; b++)
                if (fbe[b]) m_data[fway][fset][b*8 +: 8] = fline[b*8 +: 8];
            touch(fset, fway, 1);
        end
        pend_v   = acc && e_hit;
        pend_set = rset;
        pend_way = e_way;
        if (fl) begin
            busy_left = SETS;
            for (int w = 0; w < WAYS; w++)
                for (int s = 0; s < SETS; s++) m_valid[w][s] = 0;
        end else if (!idle) begin
            busy_left--;
        end
        @(posedge clk);
        #1;
        check_eq("busy", busy_o, busy_left != 0);
        check_eq("resp_valid", resp_valid_o, acc);
        if (acc) begin
            check_eq("resp_hit", resp_hit_o, e_hit);
            check_eq("resp_way", resp_way_o, e_way);
            check_eq("resp_line", resp_line_o, e_line);
            check_eq("resp_victim", resp_victim_way_o, e_vict);
        end
    endtask

    task automatic idle_cycle();
        drive_cycle(0, 0, 0, '0, '0, '0, 0, 0, '0, 0);
    endtask

    task automatic fill(input int s, input int w, input logic [TAG_W-1:0] t, input logic [LINE_W-1:0] l);
        drive_cycle(1, s, w, t, l, '1, 0, 0, '0, 0);
    endtask

    task automatic lookup(input int s, input logic [TAG_W-1:0] t);
        drive_cycle(0, 0, 0, '0, '0, '0, 1, s, t, 0);
    endtask

    task automatic count_busy(input string tag);
        int n = 0;
        while (busy_o === 1'b1 && n < 200) begin
            idle_cycle();
            n++;
        end
        check_eq(tag, n, 64);
    endtask

    task automatic random_traffic(input int cycles);
        logic [TAG_W-1:0] tags [4];
        int               sets [4];
        bit               fv, rv, fl;
        int               fs, fw, rs;
        logic [BE_W-1:0]  be;
        tags[0] = 22'h001234; tags[1] = 22'h0abcde; tags[2] = 22'h3fffff; tags[3] = 22'h000000;
        sets[0] = 0; sets[1] = 1; sets[2] = 33; sets[3] = 63;
        for (int i = 0; i < cycles; i++) begin
            fv = ($urandom_range(0, 9) < 3);
            rv = ($urandom_range(0, 9) < 6);
            fl = ($urandom_range(0, 299) == 0);
            fs = sets[$urandom_range(0, 3)];
            fw = $urandom_range(0, WAYS - 1);
            rs = sets[$urandom_range(0, 3)];
            be = m_written[fw][fs] ? BE_W'($urandom) : '1;
            drive_cycle(fv, fs, fw, tags[$urandom_range(0, 3)],
                        {$urandom, $urandom, $urandom, $urandom}, be,
                        rv, rs, tags[$urandom_range(0, 3)], fl);
        end
    endtask

    localparam logic [LINE_W-1:0] LINE_A = 128'hAAAA_0001_AAAA_0002_AAAA_0003_AAAA_0004;

    initial begin
        for (int w = 0; w < WAYS; w++)
            for (int s = 0; s < SETS; s++) begin
                m_written[w][s] = 0;
                m_data[w][s]    = '0;
            end
        rstn_i       = 1'b0;
        flush_i      = 1'b0;
        req_valid_i  = 1'b1;
        req_set_i    = '0;
        req_tag_i    = '0;
        fill_valid_i = 1'b0;
        fill_set_i   = '0;
        fill_way_i   = '0;
        fill_tag_i   = '0;
        fill_line_i  = '0;
        fill_be_i    = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_busy", busy_o, 1);
        check_eq("rst_ready", req_ready_o, 0);
        check_eq("rst_resp_valid", resp_valid_o, 0);
        check_eq("rst_resp_hit", resp_hit_o, 0);
        check_eq("rst_resp_way", resp_way_o, 0);
        check_eq("rst_resp_line", resp_line_o, 0);
        check_eq("rst_victim", resp_victim_way_o, 0);
        req_valid_i = 1'b0;
        rstn_i      = 1'b1;
        count_busy("init_len");
        check_eq("ready_after_init", req_ready_o, 1);

        fill(5, 1, 22'h1234, LINE_A);
        lookup(5, 22'h1234);
        check_eq("t2_hit", resp_hit_o, 1);
        check_eq("t2_way", resp_way_o, 1);
        check_eq("t2_line", resp_line_o, LINE_A);

        lookup(5, 22'h4321);
        check_eq("t3_hit", resp_hit_o, 0);
        check_eq("t3_line", resp_line_o, 0);
        check_eq("t3_victim", resp_victim_way_o, 0);

        fill(9, 0, 22'h0111, {4{32'h1111_0000}});
        fill(9, 1, 22'h0222, {4{32'h2222_0000}});
        lookup(9, 22'h0111);
        check_eq("t4_hit_way0", resp_way_o, 0);
        idle_cycle();
        lookup(9, 22'h0333);
        check_eq("t4_victim", resp_victim_way_o, 1);
        for (int r = 0; r < 3; r++) begin
            fill(9, int'(resp_victim_way_o), 22'(22'h0400 + r), {4{32'(r)}});
            lookup(9, 22'h0333);
        end

        drive_cycle(1, 20, 0, 22'h0555, {4{32'h5555_5555}}, '1, 1, 5, 22'h1234, 0);
        check_eq("t5_blocked_resp", resp_valid_o, 0);
        lookup(5, 22'h1234);
        check_eq("t5_accept", resp_valid_o, 1);

        lookup(5, 22'h1234);
        drive_cycle(0, 0, 0, '0, '0, '0, 0, 0, '0, 1);
        count_busy("t6_flush_len");
        lookup(5, 22'h1234);
        check_eq("t6_hit_after_flush", resp_hit_o, 0);

        random_traffic(1500);

        rstn_i = 1'b0;
        #1;
        check_eq("midrst_busy", busy_o, 1);
        check_eq("midrst_ready", req_ready_o, 0);
        check_eq("midrst_resp_valid", resp_valid_o, 0);
        @(posedge clk);
        #1;
        model_reset();
        rstn_i = 1'b1;
        count_busy("midrst_init_len");
        random_traffic(1000);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish, got running, expected done");
        $fatal(1);
    end

endmodule
